// File: rtl/inv_cipher_seq_pkg.sv
// Shared AES decryption primitives: inverse S-box, GF(2^8) multipliers,
// FSM encoding and the supported Nr/Nk pairings.
package inv_cipher_seq_pkg;

  localparam int NK_128 = 4;
  localparam int NR_128 = 10;
  localparam int NK_192 = 6;
  localparam int NR_192 = 12;
  localparam int NK_256 = 8;
  localparam int NR_256 = 14;

  typedef enum logic {
    IDLE  = 1'b0,
    ROUND = 1'b1
  } fsm_state_t;

  function automatic int nr_of_nk(input int nk);
    return nk + 6;
  endfunction

  function automatic bit params_supported(input int nr, input int nk);
    return ((nk == NK_128) && (nr == NR_128)) ||
           ((nk == NK_192) && (nr == NR_192)) ||
           ((nk == NK_256) && (nr == NR_256));
  endfunction

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  // Multiply by x modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul_09(input logic [7:0] b);
    logic [7:0] x8;
    x8 = xtime(xtime(xtime(b)));
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul_0b(input logic [7:0] b);
    logic [7:0] x2;
    logic [7:0] x8;
    x2 = xtime(b);
    x8 = xtime(xtime(x2));
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul_0d(input logic [7:0] b);
    logic [7:0] x4;
    logic [7:0] x8;
    x4 = xtime(xtime(b));
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul_0e(input logic [7:0] b);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // One column, row 0 in the top byte.
  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gf_mul_0e(a0) ^ gf_mul_0b(a1) ^ gf_mul_0d(a2) ^ gf_mul_09(a3),
            gf_mul_09(a0) ^ gf_mul_0e(a1) ^ gf_mul_0b(a2) ^ gf_mul_0d(a3),
            gf_mul_0d(a0) ^ gf_mul_09(a1) ^ gf_mul_0e(a2) ^ gf_mul_0b(a3),
            gf_mul_0b(a0) ^ gf_mul_0d(a1) ^ gf_mul_09(a2) ^ gf_mul_0e(a3)};
  endfunction

endpackage

// File: rtl/inv_cipher_seq_round.sv
// Combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module inv_round
  import inv_cipher_seq_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last,
  output logic [127:0] state_out
);

  logic [127:0] added;
  logic [127:0] mixed;

  genvar gi;

  // Byte gi sits at row gi%4, column gi/4; row r is rotated right by r columns.
  generate
    for (gi = 0; gi < 16; gi++) begin : g_byte
      localparam int ROW = gi % 4;
      localparam int COL = gi / 4;
      localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
      assign added[127-8*gi -: 8] = inv_sbox(state_in[127-8*SRC -: 8]) ^ round_key[127-8*gi -: 8];
    end

    for (gi = 0; gi < 4; gi++) begin : g_col
      assign mixed[127-32*gi -: 32] = inv_mix_column(added[127-32*gi -: 32]);
    end
  endgenerate

  assign state_out = last ? added : mixed;

endmodule

// File: rtl/inv_cipher_seq.sv
// Iterative AES inverse cipher: one shared round datapath, one round per
// clock, result registered on plain_out with a one-cycle done pulse.
module inv_cipher_seq
  import inv_cipher_seq_pkg::*;
#(
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [127:0]           cipher_in,
  input  logic [128*(Nr+1)-1:0]  w,
  output logic [127:0]           plain_out,
  output logic                   busy,
  output logic                   done
);

  localparam int RC_W = $clog2(Nr);

  generate
    if (!params_supported(Nr, Nk) || (Nr != nr_of_nk(Nk))) begin : g_bad_params
      $error("inv_cipher_seq: unsupported Nr/Nk pairing");
    end
  endgenerate

  fsm_state_t        fsm_reg;
  fsm_state_t        fsm_next;
  logic [RC_W-1:0]   rc_reg;
  logic [127:0]      state_reg;
  logic [127:0]      plain_out_reg;
  logic              done_reg;

  logic              load_en;
  logic              step_en;
  logic              finish_en;
  logic              rc_zero;
  logic [127:0]      round_key;
  logic [127:0]      round_out;
  logic [127:0]      round_keys [0:Nr];

  genvar gi;
  generate
    for (gi = 0; gi <= Nr; gi++) begin : g_rk
      assign round_keys[gi] = w[gi*128 +: 128];
    end
  endgenerate

  assign rc_zero   = (rc_reg == '0);
  assign round_key = round_keys[rc_reg];

  inv_round u_inv_round (
    .state_in  (state_reg),
    .round_key (round_key),
    .last      (rc_zero),
    .state_out (round_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_reg <= IDLE;
    end else begin
      fsm_reg <= fsm_next;
    end
  end

  always_comb begin
    fsm_next = fsm_reg;
    case (fsm_reg)
      IDLE:    if (start) fsm_next = ROUND;
      ROUND:   if (rc_zero) fsm_next = IDLE;
      default: fsm_next = IDLE;
    endcase
  end

  // start is only honoured in IDLE, so a request during rounds has no effect.
  always_comb begin
    load_en   = 1'b0;
    step_en   = 1'b0;
    finish_en = 1'b0;
    busy      = 1'b0;
    case (fsm_reg)
      IDLE: load_en = start;
      ROUND: begin
        busy      = 1'b1;
        finish_en = rc_zero;
        step_en   = !rc_zero;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= '0;
      rc_reg        <= '0;
      plain_out_reg <= '0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= finish_en;
      if (load_en) begin
        state_reg <= cipher_in ^ round_keys[Nr];
        rc_reg    <= RC_W'(Nr - 1);
      end else if (step_en) begin
        state_reg <= round_out;
        rc_reg    <= rc_reg - RC_W'(1);
      end
      if (finish_en) begin
        plain_out_reg <= round_out;
      end
    end
  end

  assign plain_out = plain_out_reg;
  assign done      = done_reg;

endmodule
